// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline sequencer with stall/redirect counters
//
// Purpose:
//   Central sequencer for the five-stage pipeline. Drives the PC enable, the
//   four stage-register enables and the bubble-insert (flush) controls. It
//   resolves data-cache waits, load-use hazards, fetch misses, MEM-stage
//   redirects and halt through a three-state FSM. It also keeps saturating
//   stall and redirect counters.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   ihit                fetch for the current PC completes this cycle
//   dhit                MEM-stage data access completes this cycle
//   mem_dreq            MEM-stage instruction is a load or store
//   mem_redirect        MEM-stage PC source is not PC+4
//   mem_halt            MEM-stage instruction is halt
//   ex_dren, ex_wsel    EX-stage load flag and destination register
//   id_rs, id_rt        ID-stage source registers
//   id_uses_rt          ID-stage instruction reads rt
//   pc_en               PC register loads the next PC
//   pipe1_en..pipe4_en  IF/ID, ID/EX, EX/MEM, MEM/WB load enables
//   flush1..flush3      load a bubble into pipe1..pipe3 (only with enable high)
//   halt                processor halted, sticky until reset
//   stall_cnt           cycles with pipe4_en low while not halted (saturating)
//   redir_cnt           accepted redirects (saturating)

module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dreq,
    input  logic             mem_redirect,
    input  logic             mem_halt,
    input  logic             ex_dren,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    output logic             pc_en,
    output logic             pipe1_en,
    output logic             pipe2_en,
    output logic             pipe3_en,
    output logic             pipe4_en,
    output logic             flush1,
    output logic             flush2,
    output logic             flush3,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic load_use;
    logic tail_decode;   // evaluate the redirect / load-use / fetch-miss tiers
    logic redir_take;
    logic stall_take;

    // Register 0 is hardwired to zero, so a load targeting it never creates
    // a hazard.
    assign load_use = ex_dren && (ex_wsel != 5'd0) &&
                      ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

    always_comb begin
        pc_en       = 1'b1;
        pipe1_en    = 1'b1;
        pipe2_en    = 1'b1;
        pipe3_en    = 1'b1;
        pipe4_en    = 1'b1;
        flush1      = 1'b0;
        flush2      = 1'b0;
        flush3      = 1'b0;
        state_nxt   = state;
        tail_decode = 1'b0;
        redir_take  = 1'b0;

        case (state)
            RUN: begin
                if (mem_halt || (mem_dreq && !dhit)) begin
                    pc_en     = 1'b0;
                    pipe1_en  = 1'b0;
                    pipe2_en  = 1'b0;
                    pipe3_en  = 1'b0;
                    pipe4_en  = 1'b0;
                    state_nxt = mem_halt ? HALTED : DWAIT;
                end else begin
                    tail_decode = 1'b1;
                end
            end
            DWAIT: begin
                // The EX/MEM register is frozen, so mem_redirect still
                // reflects the waiting instruction and is honoured on dhit.
                if (!dhit) begin
                    pc_en    = 1'b0;
                    pipe1_en = 1'b0;
                    pipe2_en = 1'b0;
                    pipe3_en = 1'b0;
                    pipe4_en = 1'b0;
                end else begin
                    tail_decode = 1'b1;
                    state_nxt   = RUN;
                end
            end
            default: begin
                // HALTED, and the unused encoding: freeze everything.
                pc_en     = 1'b0;
                pipe1_en  = 1'b0;
                pipe2_en  = 1'b0;
                pipe3_en  = 1'b0;
                pipe4_en  = 1'b0;
                state_nxt = HALTED;
            end
        endcase

        if (tail_decode) begin
            if (mem_redirect) begin
                // Younger instructions are squashed, so their hazards and any
                // outstanding fetch no longer matter.
                flush1     = 1'b1;
                flush2     = 1'b1;
                flush3     = 1'b1;
                redir_take = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, push a bubble into ID/EX.
                pc_en    = 1'b0;
                pipe1_en = 1'b0;
                flush2   = 1'b1;
            end else if (!ihit) begin
                // Hold PC, let older stages drain, bubble into IF/ID.
                pc_en  = 1'b0;
                flush1 = 1'b1;
            end
        end
    end

    assign stall_take = (state != HALTED) && !pipe4_en;
    assign halt       = (state == HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall_take && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redir_take && (redir_cnt != {CNT_W{1'b1}})) begin
                redir_cnt <= redir_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b1;
    logic        dhit = 1'b0;
    logic        mem_dreq = 1'b0;
    logic        mem_redirect = 1'b0;
    logic        mem_halt = 1'b0;
    logic        ex_dren = 1'b0;
    logic [4:0]  ex_wsel = 5'd0;
    logic [4:0]  id_rs = 5'd0;
    logic [4:0]  id_rt = 5'd0;
    logic        id_uses_rt = 1'b0;

    logic        pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en;
    logic        flush1, flush2, flush3, halt;
    logic [31:0] stall_cnt, redir_cnt;

    logic        s_dreq = 1'b0;
    logic        s_dhit = 1'b1;
    logic        s_pc_en, s_p1, s_p2, s_p3, s_p4, s_f1, s_f2, s_f3, s_halt;
    logic [3:0]  s_stall_cnt, s_redir_cnt;

    int total = 0;
    int bad = 0;

    // {pc_en, pipe1..4_en, flush1..3}
    localparam logic [7:0] ALL1  = 8'b11111_000;
    localparam logic [7:0] ALL0  = 8'b00000_000;
    localparam logic [7:0] REDIR = 8'b11111_111;
    localparam logic [7:0] LU    = 8'b00111_010;
    localparam logic [7:0] IMISS = 8'b01111_100;

    logic [7:0] en_v;
    assign en_v = {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en, flush1, flush2, flush3};

    always #5 CLK = ~CLK;

    pipe_ctrl #(.CNT_W(32)) u_dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
        .mem_redirect(mem_redirect), .mem_halt(mem_halt), .ex_dren(ex_dren),
        .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .pc_en(pc_en), .pipe1_en(pipe1_en), .pipe2_en(pipe2_en), .pipe3_en(pipe3_en),
        .pipe4_en(pipe4_en), .flush1(flush1), .flush2(flush2), .flush3(flush3),
        .halt(halt), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_sat (
        .CLK(CLK), .RST(RST), .ihit(1'b1), .dhit(s_dhit), .mem_dreq(s_dreq),
        .mem_redirect(1'b0), .mem_halt(1'b0), .ex_dren(1'b0),
        .ex_wsel(5'd0), .id_rs(5'd0), .id_rt(5'd0), .id_uses_rt(1'b0),
        .pc_en(s_pc_en), .pipe1_en(s_p1), .pipe2_en(s_p2), .pipe3_en(s_p3),
        .pipe4_en(s_p4), .flush1(s_f1), .flush2(s_f2), .flush3(s_f3),
        .halt(s_halt), .stall_cnt(s_stall_cnt), .redir_cnt(s_redir_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle;
        @(negedge CLK);
    endtask

    task automatic idle_inputs;
        ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; mem_redirect = 1'b0;
        mem_halt = 1'b0; ex_dren = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0;
        id_rt = 5'd0; id_uses_rt = 1'b0;
    endtask

    initial begin
        // Reset state: outputs follow the RUN decode while RST is high.
        idle_inputs();
        #2;
        chk("rst_en", 32'(en_v), 32'(ALL1));
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_redir", redir_cnt, 32'd0);
        next_cycle();
        RST = 1'b0;

        // Idle run
        for (int i = 0; i < 10; i++) begin
            next_cycle(); #1;
            chk("idle_en", 32'(en_v), 32'(ALL1));
        end
        chk("idle_stall", stall_cnt, 32'd0);

        // Fetch miss: IF/ID gets a bubble, MEM/WB keeps moving
        next_cycle(); ihit = 1'b0; #1;
        chk("imiss_en", 32'(en_v), 32'(IMISS));
        next_cycle(); ihit = 1'b1; #1;
        chk("imiss_stall", stall_cnt, 32'd0);

        // Data miss for three cycles, then dhit
        mem_dreq = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            #1;
            chk("dmiss_en", 32'(en_v), 32'(ALL0));
        end
        next_cycle(); dhit = 1'b1; #1;
        chk("dhit_en", 32'(en_v), 32'(ALL1));
        next_cycle(); mem_dreq = 1'b0; dhit = 1'b0; #1;
        chk("dmiss_stall", stall_cnt, 32'd3);
        chk("dmiss_back_run", 32'(en_v), 32'(ALL1));

        // Load-use variants
        next_cycle(); ex_dren = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5; #1;
        chk("lu_rs", 32'(en_v), 32'(LU));
        next_cycle(); ex_wsel = 5'd0; id_rs = 5'd0; #1;
        chk("lu_r0", 32'(en_v), 32'(ALL1));
        next_cycle(); ex_wsel = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0; #1;
        chk("lu_rt_unused", 32'(en_v), 32'(ALL1));
        next_cycle(); id_uses_rt = 1'b1; #1;
        chk("lu_rt_used", 32'(en_v), 32'(LU));
        next_cycle(); ex_dren = 1'b0; #1;
        chk("lu_stall", stall_cnt, 32'd3);

        // Data request hitting in the same cycle does not stall
        next_cycle(); idle_inputs(); mem_dreq = 1'b1; dhit = 1'b1; #1;
        chk("dreq_hit", 32'(en_v), 32'(ALL1));

        // Redirect beats load-use and fetch miss
        next_cycle(); idle_inputs();
        mem_redirect = 1'b1; ex_dren = 1'b1; ex_wsel = 5'd7; id_rs = 5'd7; ihit = 1'b0; #1;
        chk("redir_en", 32'(en_v), 32'(REDIR));
        next_cycle(); idle_inputs(); #1;
        chk("redir_cnt1", redir_cnt, 32'd1);
        chk("redir_stall", stall_cnt, 32'd3);

        // Redirect pending behind a data miss is taken on the dhit cycle
        next_cycle(); mem_dreq = 1'b1; dhit = 1'b0; mem_redirect = 1'b1; #1;
        chk("redir_miss_en", 32'(en_v), 32'(ALL0));
        next_cycle(); dhit = 1'b1; #1;
        chk("redir_dhit_en", 32'(en_v), 32'(REDIR));
        next_cycle(); idle_inputs(); #1;
        chk("redir_cnt2", redir_cnt, 32'd2);
        chk("redir_miss_stall", stall_cnt, 32'd4);

        // Halt: enables drop that cycle, halt rises on the next
        next_cycle(); mem_halt = 1'b1; #1;
        chk("halt_en", 32'(en_v), 32'(ALL0));
        chk("halt_pre", 32'(halt), 32'd0);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            {ihit, dhit, mem_dreq, mem_redirect, mem_halt, ex_dren, id_uses_rt} = 7'($urandom);
            ex_wsel = 5'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
            #1;
            chk("halted_flag", 32'(halt), 32'd1);
            chk("halted_en", 32'(en_v), 32'(ALL0));
        end
        chk("halted_stall", stall_cnt, 32'd5);
        chk("halted_redir", redir_cnt, 32'd2);

        // Asynchronous reset mid-cycle
        next_cycle(); idle_inputs(); #2;
        RST = 1'b1; #1;
        chk("arst_halt", 32'(halt), 32'd0);
        chk("arst_stall", stall_cnt, 32'd0);
        chk("arst_redir", redir_cnt, 32'd0);
        next_cycle(); RST = 1'b0;
        next_cycle(); #1;
        chk("arst_run_en", 32'(en_v), 32'(ALL1));
        chk("arst_run_halt", 32'(halt), 32'd0);

        // Saturation on the 4-bit instance
        chk("sat_start", 32'(s_stall_cnt), 32'd0);
        s_dreq = 1'b1; s_dhit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            next_cycle(); #1;
            chk("sat_stall", 32'(s_stall_cnt), (i < 15) ? 32'(i) : 32'd15);
        end
        chk("sat_pc_en", 32'(s_pc_en), 32'd0);
        chk("sat_redir", 32'(s_redir_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the five-stage pipeline.
- Drives the PC enable and the enables of the four stage registers (pipe1 IF/ID, pipe2 ID/EX, pipe3 EX/MEM, pipe4 MEM/WB), plus the bubble-insert (flush) controls.
- Resolves data-cache waits, load-use hazards, instruction-fetch misses, MEM-stage redirects and halt, through a small FSM.
- Also keeps saturating stall and redirect performance counters.

Parameters:
CNT_W, 32, width of stall_cnt and redir_cnt

Ports:
CLK  in  1  clock, all state updates on the rising edge
RST  in  1  reset; one clock; reset is asynchronous and active-high
ihit  in  1  instruction fetch for the current PC completes this cycle
dhit  in  1  data access in MEM completes this cycle
mem_dreq  in  1  MEM-stage instruction is a load or store (d_ren|d_wen)
mem_redirect  in  1  MEM-stage PCSrc is not ADD4 (taken branch, j, jal, jr)
mem_halt  in  1  MEM-stage instruction is halt
ex_dren  in  1  EX-stage instruction is a load
ex_wsel  in  5  EX-stage destination register
id_rs  in  5  ID-stage rs
id_rt  in  5  ID-stage rt
id_uses_rt  in  1  ID-stage instruction reads rt
pc_en  out  1  PC register loads next PC
pipe1_en..pipe4_en  out  1 each  stage register load enables
flush1, flush2, flush3  out  1 each  load a bubble (all-zero, wen=0) into pipe1/2/3 instead of data; only meaningful with the matching enable high
halt  out  1  processor halted, sticky
stall_cnt  out  CNT_W  cycles with pipe4_en=0 while not HALTED
redir_cnt  out  CNT_W  accepted redirects

Behaviour:
- States: RUN, DWAIT, HALTED. Reset state is RUN.
- Reset values: halt=0, both counters=0. Outputs are combinational from state and inputs; during reset they follow the RUN decode.
- Default in RUN: all enables=1, all flushes=0.
- RUN priority, highest first:
  - P1: mem_halt=1. All enables=0. Next state HALTED.
  - P2: mem_dreq=1 and dhit=0. All enables=0. Next state DWAIT.
  - P3: mem_redirect=1. All enables=1; flush1=flush2=flush3=1. redir_cnt+1. An outstanding fetch is abandoned; ihit is ignored.
  - P4: load-use. Condition: ex_dren=1, ex_wsel!=0, and (ex_wsel==id_rs or (id_uses_rt and ex_wsel==id_rt)). Output: pc_en=0, pipe1_en=0, pipe2_en=1 with flush2=1, pipe3_en=pipe4_en=1.
  - P5: ihit=0. pc_en=0; pipe1_en=1 with flush1=1; pipe2..4_en=1.
  - mem_dreq=1 with dhit=1 in the same cycle does not stall; evaluation continues at P3.
- DWAIT:
  - dhit=0: all enables=0; stay in DWAIT.
  - dhit=1: decode as RUN from P3 down (P1/P2 skipped, the request is satisfied); next state RUN.
  - mem_redirect is held by the frozen EX/MEM register, so a redirect pending behind a data miss is taken on the dhit cycle.
- HALTED: all enables=0 and flushes=0; halt=1 from the first cycle in HALTED. The only exit is RST.
- Counters:
  - stall_cnt increments on any cycle in RUN/DWAIT with pipe4_en=0.
  - Both counters saturate at all-ones and do not wrap.
- Register 0 is never a hazard source.
- Simultaneous events follow the priority list. A redirect suppresses load-use and fetch stalls, because the squashed instructions are discarded.
- RST asserted mid-DWAIT or in HALTED returns the block to RUN with counters cleared; the outstanding data access is abandoned.

Test Plan:
- Idle run: ihit=1, no hazards, 10 cycles -> all enables=1, flushes=0, stall_cnt=0.
- Data miss: mem_dreq=1, dhit low for 3 cycles then high -> enables 0 for 3 cycles (state DWAIT), all enables 1 on the dhit cycle, stall_cnt=3, state RUN afterwards.
- Load-use: ex_dren=1, ex_wsel=5, id_rs=5 -> pc_en=0, pipe1_en=0, flush2=1, pipe3/4_en=1. Repeat with ex_wsel=0 -> no stall. Repeat with id_rt=5, id_uses_rt=0 -> no stall.
- Redirect beats hazard: mem_redirect=1 together with the load-use condition and ihit=0 -> all enables=1, flush1..3=1, redir_cnt=1.
- Halt then reset: mem_halt=1 -> enables 0 that cycle, halt=1 the next cycle and held for 20 cycles regardless of inputs; assert RST asynchronously mid-cycle -> halt=0, counters=0, state RUN.
- Saturation: CNT_W=4, hold a data miss for 20 cycles -> stall_cnt stops at 15.
